// File: rtl/rsc_encoder_pkg.sv
// rsc_encoder_pkg
//   Shared definitions for the recursive systematic convolutional encoder:
//   precision selector, LLR word type, bipolar +1.0/-1.0 encodings for both
//   floating-point precisions, FSM state type and the tap-XOR helper used by
//   every trellis computation.
package rsc_encoder_pkg;

  typedef enum logic {
    PREC_SINGLE,
    PREC_DOUBLE
  } precision_e;

  // Widest supported LLR word; narrower words take the low bits.
  typedef logic [63:0] llr_word_t;

  localparam llr_word_t SINGLE_POS = 64'h0000_0000_3F80_0000;
  localparam llr_word_t SINGLE_NEG = 64'h0000_0000_BF80_0000;
  localparam llr_word_t DOUBLE_POS = 64'h3FF0_0000_0000_0000;
  localparam llr_word_t DOUBLE_NEG = 64'hBFF0_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_DONE
  } state_e;

  // XOR of the bits selected by a polynomial tap mask.
  function automatic logic tap_parity(input logic [31:0] taps, input logic [31:0] bits);
    return ^(taps & bits);
  endfunction

  // Bipolar mapping of a code bit: 1 -> +1.0, 0 -> -1.0.
  function automatic llr_word_t bipolar_word(input logic b, input precision_e prec);
    llr_word_t word;
    if (prec == PREC_DOUBLE) word = b ? DOUBLE_POS : DOUBLE_NEG;
    else                     word = b ? SINGLE_POS : SINGLE_NEG;
    return word;
  endfunction

endpackage

// File: rtl/rsc_encoder_step.sv
// rsc_step
//   One combinational trellis step of the RSC encoder.
//   Ports:
//     i_u       in   1       information bit for this symbol
//     i_s       in   M       current shift-register state, s[M-1] newest
//     o_fb      out  1       feedback parity over s (the u that forces w=0)
//     o_out     out  NOUT    code bits, one per output polynomial
//     o_s_next  out  M       state after this symbol
//   Polynomial bit M taps the feedback bit w, bits M-1..0 tap s[M-1..0].
module rsc_step
  import rsc_encoder_pkg::*;
#(
  parameter int M         = 2,
  parameter int NOUT      = 2,
  parameter int RECURSIVE = 7,
  parameter int POLY [NOUT] = '{5, 7}
) (
  input  logic            i_u,
  input  logic [M-1:0]    i_s,
  output logic            o_fb,
  output logic [NOUT-1:0] o_out,
  output logic [M-1:0]    o_s_next
);

  logic w_w;

  // The MSB of RECURSIVE lines up with bit M of the zero-extended state,
  // which is always 0, so only the state taps contribute here.
  assign o_fb = tap_parity(32'(RECURSIVE), 32'(i_s));
  assign w_w  = i_u ^ o_fb;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
    assign o_out[gi] = tap_parity(32'(POLY[gi]), 32'({w_w, i_s}));
  end

  if (M > 1) begin : g_shift
    assign o_s_next = {w_w, i_s[M-1:1]};
  end else begin : g_single
    assign o_s_next = w_w;
  end

endmodule

// File: rtl/rsc_encoder.sv
// rsc_encoder
//   Block RSC encoder producing bipolar floating-point LLR words, one symbol
//   per clock.
//   Ports:
//     clk         in   1                       rising-edge clock
//     rst_n       in   1                       asynchronous active-low reset
//     in_valid    in   1                       block-start request
//     in_ready    out  1                       high only while idle
//     DataBits    in   SYMBOLS                 information bits, bit k -> symbol k
//     out_valid   out  1                       one-cycle pulse: block complete
//     LLRVector   out  [NOUT][SYMBOLS] x BITS  bipolar code words
//     FinalState  out  log2(STATES)            encoder state after last symbol
module rsc_encoder
  import rsc_encoder_pkg::*;
#(
  parameter int BITS            = 32,
  parameter     PRECISION       = "SINGLE",
  parameter int STATES          = 4,
  parameter int BITS_PER_SYMBOL = 2,
  parameter int SYMBOLS         = 10,
  parameter int RECURSIVE       = 7,
  parameter int POLY [BITS_PER_SYMBOL] = '{5, 7},
  parameter int TERMINATE       = 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [SYMBOLS-1:0]                               DataBits,
  output logic                                             out_valid,
  output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0] LLRVector,
  output logic [$clog2(STATES)-1:0]                        FinalState
);

  localparam int M    = $clog2(STATES);
  localparam int NOUT = BITS_PER_SYMBOL;
  localparam int KW   = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

  localparam precision_e PREC     = (PRECISION == "DOUBLE") ? PREC_DOUBLE : PREC_SINGLE;
  localparam llr_word_t  POS_FULL = bipolar_word(1'b1, PREC);
  localparam llr_word_t  NEG_FULL = bipolar_word(1'b0, PREC);
  localparam logic [BITS-1:0] LLR_POS = POS_FULL[BITS-1:0];
  localparam logic [BITS-1:0] LLR_NEG = NEG_FULL[BITS-1:0];

  localparam logic [KW-1:0] LAST_K     = KW'(SYMBOLS - 1);
  localparam logic [KW-1:0] TAIL_START = KW'(SYMBOLS - M);

  state_e r_state;
  state_e w_state_next;

  logic [KW-1:0]      r_k;
  logic [M-1:0]       r_s;
  logic [SYMBOLS-1:0] r_data;
  logic [M-1:0]       r_final;
  logic [NOUT-1:0][SYMBOLS-1:0][BITS-1:0] r_llr;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_tail;
  logic                      w_u;
  logic                      w_fb;
  logic [NOUT-1:0]           w_out;
  logic [M-1:0]              w_s_next;
  logic [NOUT-1:0][BITS-1:0] w_word;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_k == LAST_K);
  // Tail symbols feed the feedback parity back in so w becomes 0 and the
  // register flushes to state 0 by the end of the block.
  assign w_tail   = (TERMINATE != 0) && (r_k >= TAIL_START);
  assign w_u      = w_tail ? w_fb : r_data[r_k];

  rsc_step #(
    .M         (M),
    .NOUT      (NOUT),
    .RECURSIVE (RECURSIVE),
    .POLY      (POLY)
  ) u_step (
    .i_u      (w_u),
    .i_s      (r_s),
    .o_fb     (w_fb),
    .o_out    (w_out),
    .o_s_next (w_s_next)
  );

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_map
    assign w_word[gi] = w_out[gi] ? LLR_POS : LLR_NEG;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_state_next = ST_ENCODE;
      ST_ENCODE: if (w_last)   w_state_next = ST_DONE;
      ST_DONE:                 w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_DONE);
  end

  // Datapath. Results are only overwritten symbol by symbol during ENCODE,
  // so the previous block stays readable until the next block's first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k     <= '0;
      r_s     <= '0;
      r_data  <= '0;
      r_final <= '0;
      r_llr   <= '0;
    end else if (w_accept) begin
      r_k    <= '0;
      r_s    <= '0;
      r_data <= DataBits;
    end else if (r_state == ST_ENCODE) begin
      r_k <= r_k + KW'(1);
      r_s <= w_s_next;
      for (int j = 0; j < NOUT; j++) begin
        r_llr[j][r_k] <= w_word[j];
      end
      if (w_last) r_final <= w_s_next;
    end
  end

  assign LLRVector  = r_llr;
  assign FinalState = r_final;

endmodule

// File: tb/tb_rsc_encoder.sv
module tb_rsc_encoder;

  localparam int SYM = 10;
  localparam int MM  = 2;
  localparam int REC = 7;
  localparam int PL0 = 5;
  localparam int PL1 = 7;

  localparam logic [31:0] SP_POS = 32'h3F80_0000;
  localparam logic [31:0] SP_NEG = 32'hBF80_0000;
  localparam logic [63:0] DP_POS = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] DP_NEG = 64'hBFF0_0000_0000_0000;

  typedef logic [SYM-1:0]       bits_t;
  typedef logic [1:0][SYM-1:0]  rows_t;

  typedef struct {
    bits_t      data;
    bits_t      t0_r0;
    bits_t      t0_r1;
    logic [1:0] t0_fs;
    bits_t      t1_r0;
    bits_t      t1_r1;
    logic [1:0] t1_fs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  bits_t DataBits = '0;

  logic rdy0, rdy1, rdy2, ov0, ov1, ov2;
  logic [1:0][SYM-1:0][31:0] llr0, llr1;
  logic [1:0][SYM-1:0][63:0] llr2;
  logic [1:0] fs0, fs1, fs2;

  int n_tests = 0;
  int n_fail  = 0;
  bits_t last_d;

  always #5 clk = ~clk;

  rsc_encoder #(.TERMINATE(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .DataBits(DataBits), .out_valid(ov0), .LLRVector(llr0), .FinalState(fs0)
  );

  rsc_encoder #(.TERMINATE(1)) dut_t1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .DataBits(DataBits), .out_valid(ov1), .LLRVector(llr1), .FinalState(fs1)
  );

  rsc_encoder #(.BITS(64), .PRECISION("DOUBLE"), .TERMINATE(1)) dut_dp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .DataBits(DataBits), .out_valid(ov2), .LLRVector(llr2), .FinalState(fs2)
  );

  // Reference: code bits as a convolution over the history of feedback bits.
  // Polynomial bit b weights w[k-M+b]; bit M is the current w[k].
  function automatic void ref_encode(input bits_t d, input bit term,
                                     output rows_t rows, output int fin);
    int w [SYM];
    int polys [2];
    polys[0] = PL0;
    polys[1] = PL1;
    rows = '0;
    for (int k = 0; k < SYM; k++) begin
      int fb;
      int u;
      fb = 0;
      for (int b = 0; b < MM; b++)
        if (k - MM + b >= 0 && ((REC >> b) & 1) == 1) fb ^= w[k-MM+b];
      u = (term && k >= SYM - MM) ? fb : int'(d[k]);
      w[k] = u ^ fb;
      for (int j = 0; j < 2; j++) begin
        int acc;
        acc = 0;
        for (int b = 0; b <= MM; b++)
          if (k - MM + b >= 0 && ((polys[j] >> b) & 1) == 1) acc ^= w[k-MM+b];
        rows[j][k] = acc[0];
      end
    end
    fin = 0;
    for (int b = 0; b < MM; b++) fin |= w[SYM-MM+b] << b;
  endfunction

  function automatic logic [639:0] exp_row32(input bits_t r);
    logic [SYM-1:0][31:0] v;
    for (int k = 0; k < SYM; k++) v[k] = r[k] ? SP_POS : SP_NEG;
    return 640'(v);
  endfunction

  function automatic logic [639:0] exp_row64(input bits_t r);
    logic [SYM-1:0][63:0] v;
    for (int k = 0; k < SYM; k++) v[k] = r[k] ? DP_POS : DP_NEG;
    return 640'(v);
  endfunction

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 640'(act), 640'(exp));
  endtask

  task automatic check_outputs(input string tag, input rows_t e0, input int f0,
                               input rows_t e1, input int f1);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s t0 row%0d", tag, j), 640'(llr0[j]), exp_row32(e0[j]));
      chk($sformatf("%s t1 row%0d", tag, j), 640'(llr1[j]), exp_row32(e1[j]));
      chk($sformatf("%s dp row%0d", tag, j), 640'(llr2[j]), exp_row64(e1[j]));
    end
    chk({tag, " t0 final"}, 640'(fs0), 640'(f0));
    chk({tag, " t1 final"}, 640'(fs1), 640'(f1));
    chk({tag, " dp final"}, 640'(fs2), 640'(f1));
  endtask

  task automatic check_model(input string tag, input bits_t d);
    rows_t r0, r1;
    int f0, f1;
    ref_encode(d, 1'b0, r0, f0);
    ref_encode(d, 1'b1, r1, f1);
    check_outputs(tag, r0, f0, r1, f1);
  endtask

  task automatic check_zero(input string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s t0 row%0d zero", tag, j), 640'(llr0[j]), 640'(0));
      chk($sformatf("%s t1 row%0d zero", tag, j), 640'(llr1[j]), 640'(0));
      chk($sformatf("%s dp row%0d zero", tag, j), 640'(llr2[j]), 640'(0));
    end
    chk({tag, " final zero"}, 640'({fs0, fs1, fs2}), 640'(0));
    chk({tag, " in_ready"}, 640'({rdy0, rdy1, rdy2}), 640'(3'b111));
    chk({tag, " out_valid"}, 640'({ov0, ov1, ov2}), 640'(0));
  endtask

  // Request a block in the next cycle; returns just after the accepting edge
  // with DataBits scrambled so late input changes would show up as errors.
  task automatic accept(input string tag, input bits_t d);
    @(negedge clk);
    DataBits = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    DataBits = SYM'($urandom);
    chk1({tag, " busy after accept"}, rdy0, 1'b0);
  endtask

  // Waits (bounded) for out_valid; returns at the sample point of the DONE cycle.
  task automatic wait_done(input string tag);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!ov0 && c < SYM + 5);
    chk({tag, " latency"}, 640'(c), 640'(SYM));
    chk1({tag, " t1 valid"}, ov1, 1'b1);
    chk1({tag, " dp valid"}, ov2, 1'b1);
    chk1({tag, " ready in DONE"}, rdy0, 1'b0);
  endtask

  task automatic post_done(input string tag);
    @(posedge clk);
    #1;
    chk1({tag, " valid drops"}, ov0, 1'b0);
    chk1({tag, " ready back"}, rdy0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    vec_t  tbl [3];
    bits_t da, db;
    int    nv;
    rows_t e0, e1;

    tbl[0] = '{10'h000, 10'h000, 10'h000, 2'd0, 10'h000, 10'h000, 2'd0};
    tbl[1] = '{10'h001, 10'h1B7, 10'h001, 2'd2, 10'h3B7, 10'h201, 2'd0};
    tbl[2] = '{10'h3FF, 10'h36D, 10'h3FF, 2'd2, 10'h16D, 10'h1FF, 2'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven blocks, with a hold check a few idle cycles later
    for (int i = 0; i < 3; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      accept(tag, tbl[i].data);
      wait_done(tag);
      e0 = {tbl[i].t0_r1, tbl[i].t0_r0};
      e1 = {tbl[i].t1_r1, tbl[i].t1_r0};
      check_outputs(tag, e0, int'(tbl[i].t0_fs), e1, int'(tbl[i].t1_fs));
      post_done(tag);
      repeat (3) @(posedge clk);
      #1;
      check_outputs({tag, " held"}, e0, int'(tbl[i].t0_fs), e1, int'(tbl[i].t1_fs));
      $display("[TB] vector %0d data=%h done", i, tbl[i].data);
    end

    // Requests while busy are dropped; accept the cycle after DONE
    da = SYM'($urandom);
    db = SYM'($urandom);
    accept("busy", da);
    nv = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      in_valid = (c == 3 || c == 11);
      DataBits = SYM'($urandom);
      @(posedge clk);
      #1;
      if (ov0) nv++;
      if (c == 3) chk1("busy ready mid-encode", rdy0, 1'b0);
      if (c == 10) begin
        chk1("busy valid at DONE", ov0, 1'b1);
        chk1("busy ready in DONE", rdy0, 1'b0);
        check_model("busy blockA", da);
      end
      if (c == 11) chk1("busy DONE request dropped", rdy0, 1'b1);
    end
    chk("busy single pulse", 640'(nv), 640'(1));
    accept("after DONE", db);
    wait_done("after DONE");
    check_model("after DONE blockB", db);
    post_done("after DONE");
    $display("[TB] busy-request sequence data=%h/%h done", da, db);

    // Asynchronous reset in the middle of a block
    da = SYM'($urandom) | 10'h001;
    db = SYM'($urandom);
    accept("abort", da);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort async");
    nv = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (ov0 || ov1 || ov2) nv++;
    end
    chk("abort no valid in reset", 640'(nv), 640'(0));
    @(negedge clk);
    rst_n = 1'b1;
    DataBits = db;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk1("abort first-edge accept", rdy0, 1'b0);
    wait_done("abort restart");
    check_model("abort restart", db);
    post_done("abort restart");
    last_d = db;
    $display("[TB] reset-abort sequence data=%h/%h done", da, db);

    // Randomized blocks against the reference model
    for (int i = 0; i < 25; i++) begin
      string tag;
      tag = $sformatf("rand%0d", i);
      da = SYM'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      accept(tag, da);
      check_model({tag, " prev held"}, last_d);
      wait_done(tag);
      check_model(tag, da);
      post_done(tag);
      last_d = da;
      $display("[TB] %s data=%h done", tag, da);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
